// File: rtl/bcd_bin_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_t        : converter FSM states (idle, shifting, result held)
//   BCD_DIGIT_W    : bits per BCD digit
//   BCD_MAX_DIGIT  : largest legal BCD digit value
//   BCD_CORR_THR   : digit value at/above which a halving correction is needed
//   BCD_CORR_SUB   : amount subtracted from a digit that needs correction
//   bcd_corr_digit : applies the per-digit correction after a right shift
package bcd_bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_CORR_THR  = 4'd8;
  localparam logic [3:0] BCD_CORR_SUB  = 4'd3;

  // A digit that received the LSB of the next-higher digit carries a weight
  // of 8 in binary but only 5 in decimal, so it must be pulled down by 3.
  function automatic logic [3:0] bcd_corr_digit(input logic [3:0] d);
    return (d >= BCD_CORR_THR) ? (d - BCD_CORR_SUB) : d;
  endfunction

endpackage

// File: rtl/bcd_bin_step.sv
// One iteration of reverse double-dabble (purely combinational).
//   work_i : {BCD field (DIGITS*4 bits), binary field (BIN_W bits)}
//   work_o : work_i shifted right by one, then every BCD digit >= 8 reduced by 3
module bcd_bin_step
  import bcd_bin_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic [DIGITS*BCD_DIGIT_W+BIN_W-1:0] work_i,
  output logic [DIGITS*BCD_DIGIT_W+BIN_W-1:0] work_o
);

  logic [DIGITS*BCD_DIGIT_W+BIN_W-1:0] shifted;

  always_comb begin
    shifted = work_i >> 1;
    work_o  = shifted;
    for (int d = 0; d < DIGITS; d++) begin
      work_o[BIN_W+d*BCD_DIGIT_W +: BCD_DIGIT_W] =
        bcd_corr_digit(shifted[BIN_W+d*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, one bit per clock (reverse double-dabble).
// Optional feature macro: BCD_BIN_CHECK_EN (illegal-digit detection).
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : BCD word offered
//   in_ready  : converter idle, can accept
//   bcd       : packed BCD operand, digit 0 = bcd[3:0]; sampled on accept
//   out_valid : result valid, held until out_ready
//   out_ready : consumer accepts result
//   bin       : binary result modulo 2**BIN_W
//   ovf       : BCD value exceeded 2**BIN_W-1
//   err       : illegal digit seen (always 0 without BCD_BIN_CHECK_EN)
module bcd_to_bin
  import bcd_bin_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIGITS*BCD_DIGIT_W-1:0] bcd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIN_W-1:0]            bin,
  output logic                        ovf,
  output logic                        err
);

  localparam int BCD_W  = DIGITS * BCD_DIGIT_W;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d, work_step;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic                illegal;

  bcd_bin_step #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_step (
    .work_i (work_q),
    .work_o (work_step)
  );

`ifdef BCD_BIN_CHECK_EN
  always_comb begin
    illegal = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) illegal = 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bin_d   = bin_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = {bcd, {BIN_W{1'b0}}};
          cnt_d   = '0;
          err_d   = illegal;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (err_q) begin
          // Illegal operand: spend a single cycle here and report a zero result.
          bin_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          work_d = work_step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            bin_d   = work_step[BIN_W-1:0];
            // Any residue left in the BCD field means the value did not fit.
            ovf_d   = |work_step[WORK_W-1:BIN_W];
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Work register is pure datapath; it is always reloaded on accept.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bin       = bin_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] bcd;
  logic        out_ready;
  logic        in_ready, out_valid, ovf, err;
  logic [9:0]  bin;
  logic        in_ready8, out_valid8, ovf8, err8;
  logic [7:0]  bin8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bcd(bcd), .out_valid(out_valid), .out_ready(out_ready),
    .bin(bin), .ovf(ovf), .err(err)
  );

  bcd_to_bin #(.DIGITS(3), .BIN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .bcd(bcd), .out_valid(out_valid8), .out_ready(out_ready),
    .bin(bin8), .ovf(ovf8), .err(err8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept one operand on both converters, then wait (bounded) for each result.
  task automatic run(input string tag, input logic [11:0] v, input int lat_e, input int lat8_e,
                     input bit chk_bin, input logic [9:0] bin_e, input logic ovf_e,
                     input logic [7:0] bin8_e, input logic ovf8_e, input logic err_e);
    int lat, lat8;
    logic [9:0] cb;
    logic [7:0] cb8;
    logic co, ce, co8, ce8;
    lat = -1; lat8 = -1; cb = '0; cb8 = '0; co = 0; ce = 0; co8 = 0; ce8 = 0;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bcd      = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bcd      = 12'hFFF;
    for (int n = 0; n < 40; n++) begin
      if (out_valid && lat < 0) begin lat = n; cb = bin; co = ovf; ce = err; end
      if (out_valid8 && lat8 < 0) begin lat8 = n; cb8 = bin8; co8 = ovf8; ce8 = err8; end
      if (lat >= 0 && lat8 >= 0) break;
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(lat_e));
    chk({tag, "_lat8"}, 32'(lat8), 32'(lat8_e));
    chk({tag, "_err"}, 32'(ce), 32'(err_e));
    chk({tag, "_err8"}, 32'(ce8), 32'(err_e));
    if (chk_bin) begin
      chk({tag, "_bin"}, 32'(cb), 32'(bin_e));
      chk({tag, "_ovf"}, 32'(co), 32'(ovf_e));
      chk({tag, "_bin8"}, 32'(cb8), 32'(bin8_e));
      chk({tag, "_ovf8"}, 32'(co8), 32'(ovf8_e));
    end
  endtask

  task automatic back_to_idle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_rdy_back8"}, 32'(in_ready8), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bcd       = 12'h000;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 255: fits both widths
    run("c255", 12'h255, 10, 8, 1'b1, 10'd255, 1'b0, 8'd255, 1'b0, 1'b0);
    back_to_idle("c255");
    // 999: 8-bit instance wraps to 999-768=231
    run("c999", 12'h999, 10, 8, 1'b1, 10'd999, 1'b0, 8'd231, 1'b1, 1'b0);
    back_to_idle("c999");
    run("c000", 12'h000, 10, 8, 1'b1, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    back_to_idle("c000");
    // 300: 8-bit instance wraps to 44
    run("c300", 12'h300, 10, 8, 1'b1, 10'd300, 1'b0, 8'd44, 1'b1, 1'b0);
    back_to_idle("c300");
    run("c256", 12'h256, 10, 8, 1'b1, 10'd256, 1'b0, 8'd0, 1'b1, 1'b0);
    back_to_idle("c256");

    // Illegal digit
`ifdef BCD_BIN_CHECK_EN
    run("c1a3", 12'h1A3, 1, 1, 1'b1, 10'd0, 1'b0, 8'd0, 1'b0, 1'b1);
`else
    run("c1a3", 12'h1A3, 10, 8, 1'b0, 10'd0, 1'b0, 8'd0, 1'b0, 1'b0);
`endif
    back_to_idle("c1a3");
    // err must clear on the next accept
    run("c087", 12'h087, 10, 8, 1'b1, 10'd87, 1'b0, 8'd87, 1'b0, 1'b0);
    back_to_idle("c087");

    // Backpressure: hold the result for 5 cycles while in_valid pulses
    out_ready = 1'b0;
    run("bp", 12'h128, 10, 8, 1'b1, 10'd128, 1'b0, 8'd128, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      bcd      = 12'h777;
      @(posedge clk); #1;
      chk("bp_ov_hold", 32'(out_valid), 32'd1);
      chk("bp_bin_hold", 32'(bin), 32'd128);
      chk("bp_ovf_hold", 32'(ovf), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_bin8_hold", 32'(bin8), 32'd128);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    back_to_idle("bp");

    // Reset while shifting (cnt=4)
    in_valid = 1'b1;
    bcd      = 12'h255;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_bin", 32'(bin), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("c042", 12'h042, 10, 8, 1'b1, 10'd42, 1'b0, 8'd42, 1'b0, 1'b0);
    back_to_idle("c042");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
